inst_fetch: RTL

//  Fetch stage that sits directly upstream of the instruction cache: owns the PC, drives the

---
 rtl/inst_fetch.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Fetch stage in front of the instruction cache. It owns the PC, issues the
// cache request, and presents the (pc, instruction) pair to decode. It also
// handles cache-miss stalls, downstream stalls, delayed branches and flush
// redirects.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        stall_ext,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        iram_en,
    output logic [31:0] iram_addr,
    input  logic [31:0] iram_rdata,
    input  logic        iram_sreq,
    output logic        iram_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    logic [31:0] r_pc;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic        r_id_adel;
    logic        r_hold_vld;
    logic [31:0] r_hold_inst;

    logic        w_stall;
    logic        w_adv;
    logic [31:0] w_pc_next;

    assign w_stall = iram_sreq | stall_ext;
    assign w_adv   = !w_stall;

    // Redirect priority: flush, then a live branch, then a branch that was
    // parked during a stall, otherwise sequential fetch.
    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (flush)
            w_pc_next = flush_pc;
        else if (br_taken)
            w_pc_next = br_target;
        else if (r_br_pend)
            w_pc_next = r_br_tgt;
    end

    // PC register: moves on every advance, and on flush even when stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pc <= RESET_PC;
        else if (flush || w_adv)
            r_pc <= w_pc_next;
    end

    // Park a branch resolved during a stall until the pipeline advances
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_pend <= 1'b0;
            r_br_tgt  <= '0;
        end else if (flush) begin
            r_br_pend <= 1'b0;
        end else if (!w_adv) begin
            if (br_taken) begin
                r_br_pend <= 1'b1;
                r_br_tgt  <= br_target;
            end
        end else begin
            r_br_pend <= 1'b0;
        end
    end

    // Decode slot: capture the fetched PC on advance, squash on flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_adel  <= 1'b0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
            r_id_adel  <= 1'b0;
        end else if (w_adv) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= r_pc;
            r_id_adel  <= (r_pc[1:0] != 2'b00);
        end
    end

    // Snapshot the cache word at the first stalled edge so decode keeps
    // seeing it while the cache port is busy with other traffic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_vld  <= 1'b0;
            r_hold_inst <= '0;
        end else if (flush || w_adv) begin
            r_hold_vld  <= 1'b0;
            r_hold_inst <= '0;
        end else if (!r_hold_vld && r_id_valid) begin
            r_hold_vld  <= 1'b1;
            r_hold_inst <= iram_rdata;
        end
    end

    assign iram_addr  = r_pc;
    assign iram_en    = (r_pc[1:0] == 2'b00) && !flush;
    assign iram_stall = w_stall;
    assign id_valid   = r_id_valid;
    assign id_pc      = r_id_pc;
    assign id_adel    = r_id_adel;
    assign id_inst    = r_id_adel  ? '0 :
                        r_hold_vld ? r_hold_inst : iram_rdata;

endmodule
